// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with per-frame snapshot and inter-digit blanking.
// Optional whole-display blinking is compiled in when DISPLAY_BLINK_EN is defined.
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] display_code,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic          snap_now;
  logic          blank_slot;
  logic          dark;
  logic [3:0]    glyph_code;

  assign snap_now   = (cnt == '0) && (idx == 2'd0);
  assign blank_slot = (cnt < BLANK_END);
  assign glyph_code = snap[{idx, 2'b00} +: 4];

  // Lock glyph set: digits 0-9, 'E', 'r'; every other code is blank.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hC:    decode = 7'b0000110;
      4'hD:    decode = 7'b0101111;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= 16'hEEEE;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= snap_now;
      if (snap_now) snap <= display_code;
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] frame_cnt;
  logic          phase;

  // frame_cnt holds snapshots seen in the current half-period, so the first half is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (!blink) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (snap_now) begin
      if (frame_cnt == FW'(BLINK_FRAMES)) begin
        frame_cnt <= FW'(1);
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign dark = blink & phase;
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink;
  assign unused_blink = blink;
  assign dark         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else if (blank_slot) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= dark ? 4'b1111 : ~(4'b0001 << idx);
      seg <= decode(glyph_code);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGIT_CYCLES=8, BLANK_CYCLES=2 (BLINK_FRAMES=2).
// Outputs are sampled 1 time unit after each rising edge; a monitor checks anode legality and timing.
module tb_seg7_scan_driver;

  localparam int DIGIT  = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = 4 * DIGIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] display_code = 16'h1234;
  logic        blink = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b1;

  seg7_scan_driver #(
    .DIGIT_CYCLES(DIGIT),
    .BLANK_CYCLES(BLANK),
    .BLINK_FRAMES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .display_code(display_code),
    .blink       (blink),
    .an          (an),
    .seg         (seg),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advances to the next sampled frame_tick pulse; a missing pulse counts as a failure.
  task automatic wait_tick();
    int k;
    for (k = 0; k < 3 * FRAME; k++) begin
      tick(1);
      if (frame_tick) break;
    end
    if (k == 3 * FRAME) check("frame_tick_timeout", 32'd0, 32'd1);
  endtask

  // Waits for a snapshot and checks the four active digit slots of that frame.
  task automatic show_frame(input string tag, input logic [27:0] exp);
    logic [3:0] exp_an;
    wait_tick();
    tick(BLANK);
    for (int d = 0; d < 4; d++) begin
      exp_an = 4'b1111;
      exp_an[d] = 1'b0;
      check({tag, "_an"}, 32'(an), 32'(exp_an));
      check({tag, "_seg"}, 32'(seg), 32'(exp[7*d +: 7]));
      if (d < 3) tick(DIGIT);
    end
  endtask

  // Anode monitor: legality, blank-gap length and frame period.
  int   cyc = 0;
  int   last_tick = -1;
  int   blank_run = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      blank_run = 0;
      last_tick = -1;
    end else begin
      if (!($countones(~an) <= 1)) check("an_legal", 32'(an), 32'hF);
      if (mon_en) begin
        if (an == 4'b1111) blank_run++;
        else begin
          if (blank_run != 0) check("blank_gap", 32'(blank_run), 32'(BLANK));
          blank_run = 0;
        end
      end
      if (frame_tick) begin
        if (last_tick >= 0) check("frame_period", 32'(cyc - last_tick), 32'(FRAME));
        last_tick = cyc;
      end
    end
  end

  initial begin
    int k;
    tick(2);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_snap", 32'(dut.snap), 32'hEEEE);
    @(negedge clk) rst_n = 1'b1;

    // Reset release with 16'h1234
    tick(1);
    check("e1_tick", 32'(frame_tick), 32'd1);
    check("e1_an", 32'(an), 32'hF);
    tick(1);
    check("e2_tick", 32'(frame_tick), 32'd0);
    check("e2_an", 32'(an), 32'hF);
    tick(1);
    for (int i = 0; i < DIGIT - BLANK; i++) begin
      check("d0_an", 32'(an), 32'b1110);
      check("d0_seg", 32'(seg), 32'b0011001);
      tick(1);
    end
    check("slot1_blank0", 32'(an), 32'hF);
    tick(1);
    check("slot1_blank1", 32'(an), 32'hF);
    tick(1);
    check("d1_an", 32'(an), 32'b1101);
    check("d1_seg", 32'(seg), 32'b0110000);

    // " Err"
    display_code = 16'hECDD;
    show_frame("err", {7'b1111111, 7'b0000110, 7'b0101111, 7'b0101111});

    // Remaining decode coverage
    display_code = 16'h7B65;
    show_frame("f7b65", {7'b1111000, 7'b1111111, 7'b0000010, 7'b0010010});
    display_code = 16'hAF98;
    show_frame("faf98", {7'b1111111, 7'b1111111, 7'b0010000, 7'b0000000});
    display_code = 16'hE0E0;
    show_frame("fe0e0", {7'b1111111, 7'b1000000, 7'b1111111, 7'b1000000});

    // Mid-frame change: current frame keeps the old snapshot
    display_code = 16'h1111;
    wait_tick();
    tick(BLANK);
    check("mid_d0", 32'(seg), 32'b1111001);
    display_code = 16'h2222;
    for (int d = 1; d < 4; d++) begin
      tick(DIGIT);
      check("mid_an", 32'(an), 32'(~(4'b0001 << d) & 4'hF));
      check("mid_old", 32'(seg), 32'b1111001);
    end
    show_frame("new1", {4{7'b0100100}});
    show_frame("new2", {4{7'b0100100}});

    // Asynchronous reset while digit 2 is lit
    for (k = 0; k < 2 * FRAME; k++) begin
      if (an == 4'b1011) break;
      tick(1);
    end
    check("find_d2", 32'(an), 32'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_snap", 32'(dut.snap), 32'hEEEE);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rel_snap", 32'(dut.snap), 32'hEEEE);
    tick(1);
    check("rel_tick", 32'(frame_tick), 32'd1);
    check("rel_snap_new", 32'(dut.snap), 32'h2222);

`ifdef DISPLAY_BLINK_EN
    // Blink: 2 frames on, 2 frames off, starting from a fresh reset
    mon_en = 1'b0;
    blink = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int f = 1; f <= 7; f++) begin
      wait_tick();
      tick(BLANK);
      check("blink_an", 32'(an), (f == 3 || f == 4 || f == 7) ? 32'hF : 32'b1110);
    end
    blink = 1'b0;
    tick(1);
    check("unblink_an", 32'(an), 32'b1110);
`endif

    tick(2 * FRAME);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed 4-digit seven-segment scan driver that consumes the 16-bit `display_code` word produced by the display mux and drives the board's common-anode display. It snapshots the word once per frame so a frame never shows a mix of old and new digits. It decodes each nibble to segments with the lock's glyph set and scans the four digits in turn. A short blanking gap between digits prevents ghosting.

## Interface
Parameters:
- `DIGIT_CYCLES`, default 50000: clock cycles per digit slot. Must be at least 4.
- `BLANK_CYCLES`, default 16: cycles at the start of each slot with all anodes off. Must be at least 1 and less than `DIGIT_CYCLES`.
- `BLINK_FRAMES`, default 64: frames per blink half-period. Used only with `DISPLAY_BLINK_EN`.

Ports:
- `clk`  in  1  system clock. This is the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `display_code`  in  16  four glyph nibbles. Bits [3:0] are digit 0 (rightmost); bits [15:12] are digit 3.
- `blink`  in  1  request to blink the whole display. Ignored unless `DISPLAY_BLINK_EN` is defined.
- `an`  out  4  digit anodes, active-low, one-hot-low or all-high.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `frame_tick`  out  1  one-cycle pulse at each frame snapshot.

## Operation
- The block has two counters:
  - `cnt` counts 0 .. `DIGIT_CYCLES`-1.
  - `idx` is the 2-bit digit index.
- On each clock, `cnt` increments. When it wraps from `DIGIT_CYCLES`-1 to 0, `idx` advances 0→1→2→3→0.
- Snapshot: when `cnt`==0 and `idx`==0 before an edge, the register `snap` takes `display_code` at that edge and `frame_tick` goes high for one cycle. `snap` changes at no other time.
- Glyph decode of `snap[4*idx+3 : 4*idx]`:
  - 0–9: standard digits. Examples: 0 → 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000.
  - 0xC: 'E' → 7'b0000110.
  - 0xD: 'r' → 7'b0101111.
  - 0xA, 0xB, 0xE, 0xF: blank → 7'b1111111.
- Hence 16'hECDD shows " Err", and 16'hEEEE shows a blank display.
- Slot behaviour:
  - While `cnt` < `BLANK_CYCLES`: `an`=4'b1111 and `seg`=7'b1111111.
  - Otherwise: `an` has only bit `idx` low, and `seg` is the decoded glyph.
- Reset values:
  - `an`=4'b1111, `seg`=7'b1111111, `frame_tick`=0.
  - `cnt`=0, `idx`=0, `snap`=16'hEEEE.
  - Blink phase = 0 and frame count = 0.
- Reset asserted mid-frame forces all of the above immediately, without waiting for a clock edge.

## Timing
- `an`, `seg` and `frame_tick` are registered. They reflect the values of `cnt`, `idx` and `snap` before each edge, so they lag those by one cycle.
- After `rst_n` rises, edge 1 captures `snap` and pulses `frame_tick`. `an`=4'b1110 first appears after edge `BLANK_CYCLES`+1.
- Frame period is 4×`DIGIT_CYCLES` cycles. Consecutive `frame_tick` pulses are exactly that far apart.
- A change on `display_code` appears on the display no earlier than the next snapshot and no later than one frame period plus one cycle.
- If `display_code` changes on the snapshot edge itself, the value present at that edge is captured.
- No two anodes are ever low in the same cycle. There are at least `BLANK_CYCLES` all-high cycles between the active periods of consecutive digits.

## Configuration
- Macro: `DISPLAY_BLINK_EN`.
- Defined:
  - A frame counter counts snapshots.
  - Every `BLINK_FRAMES` snapshots while `blink`=1, the blink phase toggles.
  - While `blink`=1 and phase=1, `an` is held at 4'b1111 for the whole frame. Scanning and snapshots continue unchanged.
  - When `blink`=0, phase and frame count clear to 0 at the next clock edge, and the display resumes at once.
- Not defined: `blink` is ignored, and no frame counter or phase register is synthesised.

## Test plan
All scenarios use `DIGIT_CYCLES`=8 and `BLANK_CYCLES`=2.
- Reset release with `display_code`=16'h1234:
  - `frame_tick` high after edge 1.
  - `an`=4'b1110 with `seg`=7'b0011001 ('4') after edge 3, for 6 cycles.
  - The next slot shows '3' on `an`=4'b1101.
- `display_code`=16'hECDD:
  - Digits 0 and 1 show 7'b0101111; digit 2 shows 7'b0000110.
  - Digit 3 has its anode low but `seg`=7'b1111111.
- Change `display_code` from 16'h1111 to 16'h2222 mid-frame: the remaining digits of that frame still show '1', and all digits show '2' from the next frame onward.
- Monitor `an` continuously: it is never anything other than 4'b1111 or a single low bit. It is 4'b1111 for exactly 2 cycles at the start of every slot.
- Assert `rst_n`=0 asynchronously while `an`=4'b1011: `an`=4'b1111 and `seg`=7'h7F with no clock edge, and after release `snap` reads 16'hEEEE until the first snapshot.
- With `DISPLAY_BLINK_EN` and `BLINK_FRAMES`=2, hold `blink`=1: the display alternates 2 frames on and 2 frames off. Dropping `blink` restores scanning within 1 cycle.
